// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform sequencer.
// FSM encoding is kept as plain localparams for legacy tools.
package wave_pkg;

   localparam int WORDS  = 16;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 4;
   localparam int BIT_W  = 3;
   localparam int REP_W  = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/wave_seq_ctrl_if.sv
// Control, pattern-load and waveform bundle of the sequencer.
// master drives requests and writes, slave produces the stream.
interface wave_seq_ctrl_if #(
   parameter int WIDTH  = wave_pkg::WIDTH,
   parameter int ADDR_W = wave_pkg::ADDR_W,
   parameter int REP_W  = wave_pkg::REP_W
);

   logic              start;
   logic              stop;
   logic              loop;
   logic [ADDR_W-1:0] last_addr;
   logic [REP_W-1:0]  rep_cnt;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic              wf;
   logic              wf_valid;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output stop,
      output loop,
      output last_addr,
      output rep_cnt,
      output we,
      output waddr,
      output wdata,
      input  wf,
      input  wf_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  stop,
      input  loop,
      input  last_addr,
      input  rep_cnt,
      input  we,
      input  waddr,
      input  wdata,
      output wf,
      output wf_valid,
      output busy,
      output done
   );

endinterface

// File: rtl/wave_pattern_mem.sv
// Pattern register file: synchronous write, asynchronous read.
// Contents are deliberately not reset so patterns survive clear.
module wave_pattern_mem #(
   parameter int WORDS = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [WORDS];

   // write port, gated by the caller
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wave_seq_ctrl.sv
// Serial waveform sequencer: plays stored words LSB first,
// one-shot with repeats or looped until stopped.
module wave_seq_ctrl
   import wave_pkg::state_t,
          wave_pkg::ST_IDLE,
          wave_pkg::ST_RUN,
          wave_pkg::ST_DONE,
          wave_pkg::REP_W;
#(
   parameter int WORDS = 16,
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            clear,
   wave_seq_ctrl_if.slave  bus
);

   localparam int AW = $clog2(WORDS);
   localparam int BW = $clog2(WIDTH);

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    word_ptr_q, word_ptr_d;
   logic [BW-1:0]    bit_ptr_q, bit_ptr_d;
   logic [REP_W-1:0] pass_left_q, pass_left_d;
   logic             loop_q, loop_d;
   logic [AW-1:0]    last_q, last_d;
   logic             wf_q, wf_d;
   logic             wf_valid_q, wf_valid_d;

   logic             mem_we;
   logic [WIDTH-1:0] rd_word;
   logic             bit_last;
   logic             pass_end;

   // writes only land while idle; clear blocks them too
   assign mem_we = bus.we && (state_q == ST_IDLE) && !clear;

   wave_pattern_mem #(
      .WORDS (WORDS),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
      .raddr_i (word_ptr_q),
      .rdata_o (rd_word)
   );

   assign bit_last = (bit_ptr_q == BIT_LAST);
   assign pass_end = bit_last && (word_ptr_q == last_q);

   // next-state, pointer and output-bit selection
   always_comb begin
      state_d     = state_q;
      word_ptr_d  = word_ptr_q;
      bit_ptr_d   = bit_ptr_q;
      pass_left_d = pass_left_q;
      loop_d      = loop_q;
      last_d      = last_q;
      wf_d        = wf_q;
      wf_valid_d  = wf_valid_q;

      unique case (1'b1)
         (state_q == ST_IDLE): begin
            wf_d       = 1'b0;
            wf_valid_d = 1'b0;
            if (bus.start) begin
               loop_d      = bus.loop;
               last_d      = bus.last_addr;
               pass_left_d = bus.rep_cnt;
               word_ptr_d  = '0;
               bit_ptr_d   = '0;
               state_d     = ST_RUN;
            end
         end

         (state_q == ST_RUN): begin
            if (bus.stop) begin
               state_d     = ST_IDLE;
               wf_d        = 1'b0;
               wf_valid_d  = 1'b0;
               word_ptr_d  = '0;
               bit_ptr_d   = '0;
               pass_left_d = '0;
            end else begin
               wf_d       = rd_word[bit_ptr_q];
               wf_valid_d = 1'b1;
               if (pass_end) begin
                  word_ptr_d = '0;
                  bit_ptr_d  = '0;
                  if (!loop_q) begin
                     if (pass_left_q != '0) begin
                        pass_left_d = pass_left_q - 1'b1;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end
               end else if (bit_last) begin
                  bit_ptr_d  = '0;
                  word_ptr_d = word_ptr_q + 1'b1;
               end else begin
                  bit_ptr_d = bit_ptr_q + 1'b1;
               end
            end
         end

         (state_q == ST_DONE): begin
            state_d    = ST_IDLE;
            wf_d       = 1'b0;
            wf_valid_d = 1'b0;
         end

         default: begin
            state_d     = ST_IDLE;
            wf_d        = 1'b0;
            wf_valid_d  = 1'b0;
            word_ptr_d  = '0;
            bit_ptr_d   = '0;
            pass_left_d = '0;
         end
      endcase
   end

   // state and output registers with synchronous clear
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= ST_IDLE;
         word_ptr_q  <= '0;
         bit_ptr_q   <= '0;
         pass_left_q <= '0;
         loop_q      <= 1'b0;
         last_q      <= '0;
         wf_q        <= 1'b0;
         wf_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_ptr_q  <= word_ptr_d;
         bit_ptr_q   <= bit_ptr_d;
         pass_left_q <= pass_left_d;
         loop_q      <= loop_d;
         last_q      <= last_d;
         wf_q        <= wf_d;
         wf_valid_q  <= wf_valid_d;
      end
   end

   assign bus.wf       = wf_q;
   assign bus.wf_valid = wf_valid_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = (state_q == ST_DONE);

endmodule

// File: doc/wave_seq_ctrl.md
WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 Parameter: WORDS, 16, pattern memory depth in words.
REQ-002 Parameter: WIDTH, 8, bits per pattern word.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin playback; honoured only in IDLE.
REQ-006 stop  input  1  abort playback; honoured only in RUN.
REQ-007 loop  input  1  1 = repeat pattern until stop; 0 = one-shot; sampled with start.
REQ-008 last_addr  input  4  index of final word played; sampled with start.
REQ-009 rep_cnt  input  4  extra passes after the first when loop=0; sampled with start.
REQ-010 we  input  1  pattern write enable.
REQ-011 waddr  input  4  pattern write address.
REQ-012 wdata  input  WIDTH  pattern write data.
REQ-013 wf  output  1  serial waveform bit, registered.
REQ-014 wf_valid  output  1  high when wf carries a pattern bit, registered.
REQ-015 busy  output  1  high when state is not IDLE.
REQ-016 done  output  1  high for exactly the cycle state is DONE.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: start=1 at edge N latches loop, last_addr, rep_cnt; sets word_ptr=0, bit_ptr=0, pass_left=rep_cnt; state becomes RUN.
REQ-019 RUN: each edge drives wf=mem[word_ptr][bit_ptr], wf_valid=1; bit 0 (LSB) first; after edge N+1, wf=mem[0][0].
REQ-020 bit_ptr increments 0..WIDTH-1 and wraps to 0; word_ptr increments only on the edge that emits bit WIDTH-1.
REQ-021 Pass end = edge emitting mem[last_addr][WIDTH-1]; word_ptr and bit_ptr return to 0.
REQ-022 At pass end with loop=1: stay in RUN, continue from word 0 with no gap cycle.
REQ-023 At pass end with loop=0 and pass_left>0: decrement pass_left, stay in RUN, no gap.
REQ-024 At pass end with loop=0 and pass_left=0: state becomes DONE; the final bit remains on wf with wf_valid=1 during DONE.
REQ-025 One-shot stream length is (last_addr+1)*WIDTH*(rep_cnt+1) consecutive valid bits.
REQ-026 DONE: next edge goes to IDLE with wf=0, wf_valid=0; start during DONE is ignored.
REQ-027 stop=1 in RUN: next edge goes to IDLE with wf=0, wf_valid=0, done never asserted; stop beats a coincident pass end.
REQ-028 start in RUN or DONE, and stop in IDLE or DONE, are ignored.
REQ-029 we=1 in IDLE writes wdata to mem[waddr] at the edge; we while busy is ignored.
REQ-030 we and start at the same IDLE edge: the write completes and playback starts; the written data is visible to playback.
REQ-031 last_addr=0 plays a single word; last_addr=15 plays the full memory.

Reset
REQ-032 clear=1 at any edge forces IDLE, wf=0, wf_valid=0, busy=0, done=0, word_ptr=0, bit_ptr=0, pass_left=0.
REQ-033 clear overrides start, stop and we in the same cycle.
REQ-034 Pattern memory contents are not cleared by clear.

Structure
REQ-035 Shared package wave_pkg holds the FSM state type (IDLE, RUN, DONE) and constants WORDS=16, WIDTH=8, ADDR_W=4, BIT_W=3.
REQ-036 Sub-module wave_pattern_mem: WORDS x WIDTH register file, synchronous write, asynchronous read; instantiated once.
REQ-037 FSM, word/bit/pass counters and output registers reside in wave_seq_ctrl.

Verification
REQ-038 Write mem[0]=8'hA5, last_addr=0, rep_cnt=0, loop=0, start -> wf = 1,0,1,0,0,1,0,1 on 8 consecutive cycles from edge N+1; done high with the 8th bit; IDLE next cycle.
REQ-039 mem[0]=8'hFF, mem[1]=8'h00, last_addr=1, rep_cnt=2 -> 48 valid bits in three identical 16-bit passes, no gaps, one done pulse.
REQ-040 loop=1, mem[0]=8'h0F, last_addr=0, stop after 20 valid bits -> wf_valid=0 at the next edge, done never high, busy=0.
REQ-041 Assert clear mid-RUN after 5 bits -> all outputs 0 next cycle; restart reproduces the original stream from bit 0, so memory is retained.
REQ-042 we during RUN to mem[0]=8'h00 -> stream unchanged; we with start together writing mem[0]=8'h01 -> first wf bit = 1.
REQ-043 start pulses during RUN and DONE -> no restart; bit count stays equal to REQ-025.
